// File: rtl/rho_l_4bits_pkg.sv
// -----------------------------------------------------------------------------
// enocoro_4b_pkg
//   Shared types and constants for the 4-bit (nibble-serial) Enocoro-128v2
//   rho datapath stages.
//
//   nibble_t     : one 4-bit datapath beat
//   byte_t       : one GF(2^8) element
//   ENOCORO_POLY : low byte of x^8+x^4+x^3+x^2+1
//   state_t      : collect / emit phases of the nibble-serial stages
//   byte_nibble  : picks the low (hi=0) or high (hi=1) nibble of a byte
// -----------------------------------------------------------------------------
package enocoro_4b_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] byte_t;

  localparam byte_t ENOCORO_POLY = 8'h1D;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  function automatic nibble_t byte_nibble(input byte_t b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/rho_l_4bits_if.sv
// -----------------------------------------------------------------------------
// rho_l_4bits_if
//   Nibble stream interface for the rho L stage: one valid/ready input
//   channel and one valid/ready output channel with a last marker.
//
//   in_valid / in_ready / in_nib              : upstream nibble channel
//   out_valid / out_ready / out_nib / out_last : downstream nibble channel
//
//   master : the surrounding logic (drives inputs, consumes outputs)
//   slave  : the L stage itself
// -----------------------------------------------------------------------------
interface rho_l_4bits_if;
  import enocoro_4b_pkg::*;

  logic    in_valid;
  logic    in_ready;
  nibble_t in_nib;
  logic    out_valid;
  logic    out_ready;
  nibble_t out_nib;
  logic    out_last;

  modport master (
    output in_valid,
    output in_nib,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_nib,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_nib,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_nib,
    output out_last
  );

endinterface

// File: rtl/rho_l_4bits_gf256_xtime.sv
// -----------------------------------------------------------------------------
// gf256_xtime
//   Combinational multiply-by-2 in GF(2^8). The byte is shifted left, bit 7
//   falls off, and the reduction byte POLY is folded back in when the bit
//   that fell off was set.
//
//   din  : 8-bit operand
//   dout : 2 * din reduced modulo the field polynomial
// -----------------------------------------------------------------------------
module gf256_xtime
  import enocoro_4b_pkg::*;
#(
  parameter byte_t POLY = ENOCORO_POLY
) (
  input  byte_t din,
  output byte_t dout
);

  assign dout = {din[6:0], 1'b0} ^ (din[7] ? POLY : 8'h00);

endmodule

// File: rtl/rho_l_4bits.sv
// -----------------------------------------------------------------------------
// rho_l_4bits
//   Nibble-serial linear layer L of the Enocoro-128v2 rho function.
//   Takes the byte pair (u0, u1) as four nibbles
//     u0[3:0], u0[7:4], u1[3:0], u1[7:4]
//   and returns (v0, v1) = (u0 ^ u1, u0 ^ 2*u1) as four nibbles
//     v0[3:0], v0[7:4], v1[3:0], v1[7:4].
//   The whole pair is buffered first, because reducing 2*u1 needs u1[7],
//   which is in the very last input nibble.
//
//   clk   : rising-edge clock
//   reset : synchronous, active-high; drops any partial or pending pair
//   bus   : slave side of rho_l_4bits_if (input and output nibble channels)
// -----------------------------------------------------------------------------
module rho_l_4bits
  import enocoro_4b_pkg::*;
#(
  parameter byte_t POLY = ENOCORO_POLY
) (
  input  logic               clk,
  input  logic               reset,
  rho_l_4bits_if.slave       bus
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  byte_t      u0;
  nibble_t    u1_lo;
  byte_t      v0;
  byte_t      v1;

  byte_t      u1_full;
  byte_t      u1_x2;
  logic       in_fire;
  logic       out_fire;

  // The handshakes depend only on the phase, so the fire terms are derived
  // from state directly rather than from the ready/valid outputs.
  assign in_fire  = bus.in_valid  && (state == COLLECT);
  assign out_fire = bus.out_ready && (state == EMIT);

  // The high nibble of u1 is never stored: it is only needed in the cycle it
  // arrives, when it completes u1 straight off the input bus.
  assign u1_full = {bus.in_nib, u1_lo};

  gf256_xtime #(
    .POLY (POLY)
  ) u_xtime (
    .din  (u1_full),
    .dout (u1_x2)
  );

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Phase change after the fourth nibble in either direction; the channel
  // handshake signals follow the phase.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (in_fire && (cnt == 2'd3)) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        if (out_fire && (cnt == 2'd3)) begin
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

  // Nibble slot counter and pair buffers. One counter serves both phases;
  // it naturally wraps to 0 after slot 3, which lines up with the phase
  // change. The L result is computed in the cycle the last input arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 2'd0;
      u0    <= 8'h00;
      u1_lo <= 4'h0;
      v0    <= 8'h00;
      v1    <= 8'h00;
    end else if (in_fire) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0: u0[3:0] <= bus.in_nib;
        2'd1: u0[7:4] <= bus.in_nib;
        2'd2: u1_lo   <= bus.in_nib;
        2'd3: begin
          v0 <= u0 ^ u1_full;
          v1 <= u0 ^ u1_x2;
        end
        default: ;
      endcase
    end else if (out_fire) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Output nibble select. Both buffers are stable during EMIT, so the
  // nibble holds by itself while downstream stalls.
  always_comb begin
    bus.out_nib  = 4'h0;
    bus.out_last = 1'b0;
    if (state == EMIT) begin
      bus.out_nib  = cnt[1] ? byte_nibble(v1, cnt[0]) : byte_nibble(v0, cnt[0]);
      bus.out_last = (cnt == 2'd3);
    end
  end

endmodule

// File: tb/tb_rho_l_4bits.sv
// -----------------------------------------------------------------------------
// tb_rho_l_4bits
//   Self-checking bench for rho_l_4bits. Pairs are driven as nibbles on the
//   falling edge, outputs are observed on the falling edge, and the expected
//   result of every pair comes from a byte-level GF(2^8) model.
// -----------------------------------------------------------------------------
module tb_rho_l_4bits;
  import enocoro_4b_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rho_l_4bits_if bus ();

  rho_l_4bits #(
    .POLY (8'h1D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Observations gathered by the stimulus tasks, judged by the test tasks.
  logic [3:0] obs_nib[$];
  int         last_cnt;
  int         last_bad;
  int         stable_bad;
  int         emit_bad;
  int         coll_bad;
  int         recv_cycles;
  logic       first_valid;
  logic       post_in_ready;
  logic       post_out_valid;
  logic [3:0] post_out_nib;
  logic       timed_out;

  logic ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  // Reference: L from the field definition. Result packed as {v1, v0}, so
  // nibble k of the returned word is the k-th output nibble.
  function automatic logic [15:0] model_pair(input logic [7:0] u0, input logic [7:0] u1);
    int         doubled;
    logic [7:0] v0;
    logic [7:0] v1;
    doubled = int'(u1) * 2;
    if (doubled >= 256) doubled = doubled ^ 'h11D;
    v0 = u0 ^ u1;
    v1 = u0 ^ doubled[7:0];
    return {v1, v0};
  endfunction

  function automatic logic [3:0] obs_at(input int i);
    return (i < obs_nib.size()) ? obs_nib[i] : 4'hx;
  endfunction

  // Feed one pair with up to max_gap idle cycles before each nibble. Ends on
  // the falling edge after the fourth accept, recording out_valid there.
  task automatic send_pair(input logic [7:0] u0, input logic [7:0] u1, input int max_gap);
    logic [15:0] nibs;
    nibs     = {u1, u0};
    coll_bad = 0;
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_nib   = 4'($urandom);
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) coll_bad++;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_nib   = nibs[i*4 +: 4];
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) coll_bad++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    first_valid  = bus.out_valid;
  endtask

  // Drain one pair. mode 0: always ready, 1: fixed stall pattern,
  // 2: random ready. With junk set, in_valid is held high with noise during
  // the emit phase. Bounded by a cycle budget.
  task automatic recv_pair(input int mode, input logic junk);
    logic [3:0] held;
    logic       stalled;
    int         cyc;
    obs_nib.delete();
    last_cnt   = 0;
    last_bad   = 0;
    stable_bad = 0;
    emit_bad   = 0;
    timed_out  = 1'b0;
    stalled    = 1'b0;
    held       = 4'h0;
    cyc        = 0;
    while (obs_nib.size() < 4) begin
      if (cyc >= 40) begin
        timed_out = 1'b1;
        break;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc < 7) ? ready_pat[cyc] : 1'b1;
        default: bus.out_ready = 1'($urandom_range(1, 0));
      endcase
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_nib   = 4'($urandom);
      end
      if (bus.out_valid === 1'b1) begin
        if (bus.in_ready !== 1'b0) emit_bad++;
        if (stalled && bus.out_nib !== held) stable_bad++;
        if (bus.out_last !== (obs_nib.size() == 3)) last_bad++;
        if (bus.out_ready) begin
          if (bus.out_last === 1'b1) last_cnt++;
          obs_nib.push_back(bus.out_nib);
          stalled = 1'b0;
        end else begin
          if (!stalled) held = bus.out_nib;
          stalled = 1'b1;
        end
      end else begin
        emit_bad++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.in_valid   = 1'b0;
    recv_cycles    = cyc;
    post_in_ready  = bus.in_ready;
    post_out_valid = bus.out_valid;
    post_out_nib   = bus.out_nib;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_nib    = 4'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_nib !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_out_nib: got %h, expected 0", bus.out_nib); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_last: got %b, expected 0", bus.out_last); end
    reset = 1'b0;
  endtask

  task automatic test_known_vectors();
    logic [7:0]  tu0 [3] = '{8'h00, 8'h12, 8'hFF};
    logic [7:0]  tu1 [3] = '{8'h80, 8'h34, 8'hFF};
    logic [15:0] texp[3] = '{16'h1D80, 16'h7A26, 16'h1C00};
    for (int t = 0; t < 3; t++) begin
      logic [15:0] e;
      e = texp[t];
      send_pair(tu0[t], tu1[t], 0);
      recv_pair(0, 1'b0);
      n_cmp++; if (first_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL vec%0d_latency: out_valid %b, expected 1", t, first_valid); end
      n_cmp++; if (recv_cycles !== 4 || timed_out) begin n_fail++; $display("[TB] FAIL vec%0d_consecutive: %0d cycles, expected 4", t, recv_cycles); end
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (obs_at(i) !== e[i*4 +: 4]) begin n_fail++; $display("[TB] FAIL vec%0d_nib%0d: got %h, expected %h", t, i, obs_at(i), e[i*4 +: 4]); end
      end
      n_cmp++; if (last_cnt !== 1 || last_bad !== 0) begin n_fail++; $display("[TB] FAIL vec%0d_last: count %0d misplaced %0d, expected 1/0", t, last_cnt, last_bad); end
      n_cmp++; if (post_in_ready !== 1'b1 || post_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL vec%0d_return: in_ready %b out_valid %b, expected 1/0", t, post_in_ready, post_out_valid); end
      n_cmp++; if (post_out_nib !== 4'h0) begin n_fail++; $display("[TB] FAIL vec%0d_idle_nib: got %h, expected 0", t, post_out_nib); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    send_pair(8'hFF, 8'hFF, 0);
    recv_pair(0, 1'b1);
    n_cmp++; if (emit_bad !== 0) begin n_fail++; $display("[TB] FAIL b2b_emit_in_ready: %0d bad cycles, expected 0", emit_bad); end
    n_cmp++; if (post_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready_after_last: got %b, expected 1", post_in_ready); end
    e = 16'h7A26;
    send_pair(8'h12, 8'h34, 0);
    recv_pair(0, 1'b0);
    n_cmp++; if (coll_bad !== 0) begin n_fail++; $display("[TB] FAIL b2b_collect: %0d bad cycles, expected 0", coll_bad); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_at(i) !== e[i*4 +: 4]) begin n_fail++; $display("[TB] FAIL b2b_nib%0d: got %h, expected %h", i, obs_at(i), e[i*4 +: 4]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    e = model_pair(8'h12, 8'h34);
    send_pair(8'h12, 8'h34, 0);
    recv_pair(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_at(i) !== e[i*4 +: 4]) begin n_fail++; $display("[TB] FAIL bp_nib%0d: got %h, expected %h", i, obs_at(i), e[i*4 +: 4]); end
    end
    n_cmp++; if (stable_bad !== 0) begin n_fail++; $display("[TB] FAIL bp_stable: %0d changes while stalled, expected 0", stable_bad); end
    n_cmp++; if (last_cnt !== 1 || last_bad !== 0) begin n_fail++; $display("[TB] FAIL bp_last: count %0d misplaced %0d, expected 1/0", last_cnt, last_bad); end
    n_cmp++; if (recv_cycles !== 7) begin n_fail++; $display("[TB] FAIL bp_cycles: got %0d, expected 7", recv_cycles); end
  endtask

  task automatic test_gaps();
    for (int p = 0; p < 4; p++) begin
      logic [7:0]  u0;
      logic [7:0]  u1;
      logic [15:0] e;
      u0 = 8'($urandom);
      u1 = 8'($urandom);
      e  = model_pair(u0, u1);
      send_pair(u0, u1, 3);
      n_cmp++; if (coll_bad !== 0) begin n_fail++; $display("[TB] FAIL gap%0d_collect: %0d bad cycles, expected 0", p, coll_bad); end
      recv_pair(0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (obs_at(i) !== e[i*4 +: 4]) begin n_fail++; $display("[TB] FAIL gap%0d_nib%0d (u0 %h u1 %h): got %h, expected %h", p, i, u0, u1, obs_at(i), e[i*4 +: 4]); end
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 16; p++) begin
      logic [7:0]  u0;
      logic [7:0]  u1;
      logic [15:0] e;
      u0 = 8'($urandom);
      u1 = (p < 4) ? (8'h80 | 8'($urandom)) : 8'($urandom);
      e  = model_pair(u0, u1);
      send_pair(u0, u1, 2);
      recv_pair(2, 1'($urandom_range(1, 0)));
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (obs_at(i) !== e[i*4 +: 4]) begin n_fail++; $display("[TB] FAIL rnd%0d_nib%0d (u0 %h u1 %h): got %h, expected %h", p, i, u0, u1, obs_at(i), e[i*4 +: 4]); end
      end
      n_cmp++; if (stable_bad !== 0 || last_bad !== 0 || emit_bad !== 0 || coll_bad !== 0) begin
        n_fail++; $display("[TB] FAIL rnd%0d_protocol: stable %0d last %0d emit %0d collect %0d, expected all 0", p, stable_bad, last_bad, emit_bad, coll_bad);
      end
    end
  endtask

  task automatic test_reset_mid_collect();
    logic [15:0] e;
    e = 16'h1D80;
    repeat (2) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_nib   = 4'($urandom_range(15, 1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstc_state: in_ready %b out_valid %b, expected 1/0", bus.in_ready, bus.out_valid); end
    send_pair(8'h00, 8'h80, 0);
    recv_pair(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_at(i) !== e[i*4 +: 4]) begin n_fail++; $display("[TB] FAIL rstc_nib%0d: got %h, expected %h", i, obs_at(i), e[i*4 +: 4]); end
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [15:0] e;
    e = 16'h1D80;
    send_pair(8'h12, 8'h34, 0);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_nib !== 4'hA) begin n_fail++; $display("[TB] FAIL rste_slot2: out_valid %b nib %h, expected 1/a", bus.out_valid, bus.out_nib); end
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rste_state: out_valid %b in_ready %b, expected 0/1", bus.out_valid, bus.in_ready); end
    n_cmp++; if (bus.out_nib !== 4'h0) begin n_fail++; $display("[TB] FAIL rste_out_nib: got %h, expected 0", bus.out_nib); end
    send_pair(8'h00, 8'h80, 0);
    recv_pair(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_at(i) !== e[i*4 +: 4]) begin n_fail++; $display("[TB] FAIL rste_nib%0d: got %h, expected %h", i, obs_at(i), e[i*4 +: 4]); end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_random();
    test_reset_mid_collect();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rho_l_4bits.md
Name: rho_l_4bits

Overview:
- Nibble-serial linear layer L of the Enocoro-128v2 rho function for the 4-bit datapath.
- Sits directly downstream of the nibble-serial S8 stage and the a-register XOR.
- Consumes the byte pair (u0, u1) as four nibbles and produces (v0, v1) = (u0 ^ u1, u0 ^ 2·u1) as four nibbles.
- Multiplication is in GF(2^8) with polynomial x^8+x^4+x^3+x^2+1.
- Buffers one full pair, because the reduction for 2·u1 depends on u1[7], which arrives last.

Parameters:
- POLY, 8'h1D, low byte of the reduction polynomial applied when the shifted-out bit is 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_nib holds a valid nibble.
- in_ready  output  1  block accepts a nibble this cycle.
- in_nib  input  4  input nibble, order u0[3:0], u0[7:4], u1[3:0], u1[7:4].
- out_valid  output  1  out_nib holds a valid nibble.
- out_ready  input  1  downstream accepts the nibble this cycle.
- out_nib  output  4  output nibble, order v0[3:0], v0[7:4], v1[3:0], v1[7:4].
- out_last  output  1  high with the fourth output nibble (v1[7:4]).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state is cleared on a clk edge with reset=1.
- Reset values: state=COLLECT, cnt=0, u0/u1/v0/v1 registers=0. Outputs after reset: in_ready=1, out_valid=0, out_nib=0, out_last=0.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Counter: cnt is a 2-bit counter, shared by both states. It selects the nibble slot and wraps 3->0.
- Input handshake: a nibble is accepted when in_valid && in_ready.
  - cnt 0, 1, 2 write u0[3:0], u0[7:4], u1[3:0].
  - No accept means no state change; in_valid gaps of any length are legal.
- Fourth accept (cnt=3), using in_nib as u1[7:4]:
  - v0 <= u0 ^ u1_full.
  - v1 <= u0 ^ ({u1_full[6:0],1'b0} ^ (u1_full[7] ? POLY : 8'h00)).
  - cnt <= 0; state <= EMIT.
- Latency: the first output nibble is valid in the cycle after the fourth input accept.
- Output handshake: a nibble transfers when out_valid && out_ready.
  - out_nib = v0[3:0], v0[7:4], v1[3:0], v1[7:4] for cnt 0..3.
  - out_nib and out_last are held stable while out_ready=0.
  - out_last = (state==EMIT && cnt==3).
- Fourth output transfer: cnt <= 0; state <= COLLECT. in_ready=1 in the next cycle; no input is accepted in the same cycle.
- Throughput: 8 cycles per pair minimum (4 in, 4 out). Input and output phases never overlap.
- out_nib outside EMIT: driven to 0.
- Reset mid-operation: a partial pair, or a pair not yet fully emitted, is discarded. The next accepted nibble is treated as u0[3:0].
- Arithmetic: all XOR, 8-bit. Shifts drop bit 7; no carry leaves the byte.

Decomposition:
- Package enocoro_4b_pkg holds:
  - nibble_t (logic [3:0]) and byte_t (logic [7:0]).
  - ENOCORO_POLY = 8'h1D.
  - state enum {COLLECT, EMIT}.
- Sub-module gf256_xtime: combinational multiply-by-2 with POLY parameter, 8-bit in/out. It is reused later by other rho stages.

Test Plan:
- Reset then u0=8'h00, u1=8'h80 fed as nibbles 0,0,0,8 with out_ready=1 -> out_nib 0,8,D,1 on 4 consecutive cycles. First output arrives the cycle after the last accept; out_last with 1.
- u0=8'h12, u1=8'h34 (nibbles 2,1,4,3) -> v0=8'h26, v1=8'h7A; out_nib 6,2,A,7.
- u0=8'hFF, u1=8'hFF -> v0=8'h00, v1=8'h1C; out_nib 0,0,C,1.
  - Then a back-to-back second pair (u0=8'h12, u1=8'h34) -> in_ready is 0 during EMIT and 1 the cycle after out_last; outputs 6,2,A,7.
- Backpressure: out_ready toggled 1,0,0,1,0,1,1 during EMIT of pair 12/34 -> each nibble held stable until transferred. Sequence 6,2,A,7 is unchanged, and exactly one out_last.
- in_valid gaps: nibbles separated by 0-3 idle cycles -> same results as the gapless run. in_ready stays 1 throughout COLLECT.
- Reset mid-operation:
  - reset=1 after 2 accepted nibbles -> next cycle in_ready=1, out_valid=0. A new pair 00/80 gives 0,8,D,1.
  - reset=1 during EMIT cnt=2 -> out_valid drops the next cycle.
